// File: rtl/calendar_day_compose_if.sv
// calendar_day_compose_if: keypad entry controls and day-number results for calendar_day_compose
//   master (keypad/set-mode side) drives : start, cancel, key_valid, key_digit[3:0], max_day[5:0]
//   slave  (calendar_day_compose) drives : number[6:0], number_valid, err, busy, tens_disp[3:0], units_disp[3:0]
interface calendar_day_compose_if;
    logic       start;
    logic       cancel;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [5:0] max_day;
    logic [6:0] number;
    logic       number_valid;
    logic       err;
    logic       busy;
    logic [3:0] tens_disp;
    logic [3:0] units_disp;
    modport master (
        output start, cancel, key_valid, key_digit, max_day,
        input  number, number_valid, err, busy, tens_disp, units_disp
    );
    modport slave (
        input  start, cancel, key_valid, key_digit, max_day,
        output number, number_valid, err, busy, tens_disp, units_disp
    );
endinterface

// File: rtl/calendar_day_compose.sv
// calendar_day_compose: builds a binary day number (1-31) from two keypad BCD digits, tens first
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : calendar_day_compose_if.slave
//           in  start (entry begin pulse), cancel (abort level), key_valid/key_digit (keypad strobe + BCD digit),
//               max_day (days in current month, values above 31 clamp to 31)
//           out number (last accepted day), number_valid (accept pulse), err (reject pulse), busy (entry active),
//               tens_disp/units_disp (preview digits)
//   Optional macro CAL_D_TIMEOUT_EN: abort entry with an err pulse after TIMEOUT_CYC idle cycles
//   (CNT_W-bit counter); without it entry waits indefinitely.
module calendar_day_compose #(
    parameter int TIMEOUT_CYC = 50000000,
    parameter int CNT_W       = 26
) (
    input logic clk,
    input logic rst_n,
    calendar_day_compose_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TENS, UNITS, CHECK} state_t;
    state_t     state, state_nx;
    logic [6:0] number, number_nx;
    logic       number_valid, number_valid_nx;
    logic       err, err_nx;
    logic       busy, busy_nx;
    logic [3:0] tens, tens_nx;
    logic [3:0] units, units_nx;
    logic [6:0] value;
    logic [5:0] lim;
    logic       key_hit;
    logic       expired;

    if (2 ** CNT_W <= TIMEOUT_CYC) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYC");
    end

    // Only BCD keys count; 10-15 are dropped everywhere without an error.
    assign key_hit = bus.key_valid && bus.key_digit <= 4'd9;
    // tens*10 + units as shifts; at most 39, fits 7 bits.
    assign value   = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
    assign lim     = bus.max_day > 6'd31 ? 6'd31 : bus.max_day;

`ifdef CAL_D_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    assign expired = cnt == CNT_W'(TIMEOUT_CYC - 1);
    // Runs only while waiting for a key; any BCD key, or leaving TENS/UNITS, restarts it.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= ((state == TENS || state == UNITS) && !key_hit) ? cnt + 1'b1 : '0;
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nx        = state;
        number_nx       = number;
        number_valid_nx = 1'b0;
        err_nx          = 1'b0;
        busy_nx         = busy;
        tens_nx         = tens;
        units_nx        = units;
        case (state)
            IDLE: if (bus.start && !bus.cancel) begin
                state_nx = TENS;
                busy_nx  = 1'b1;
                tens_nx  = '0;
                units_nx = '0;
            end
            TENS: if (bus.cancel) begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end else if (key_hit && bus.key_digit <= 4'd3) begin
                tens_nx  = bus.key_digit;
                state_nx = UNITS;
            end else if (key_hit) begin
                err_nx = 1'b1;
            end else if (expired) begin
                err_nx   = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            UNITS: if (bus.cancel) begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end else if (key_hit) begin
                units_nx = bus.key_digit;
                state_nx = CHECK;
            end else if (expired) begin
                err_nx   = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            CHECK: if (bus.cancel) begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end else if (value != 7'd0 && value <= {1'b0, lim}) begin
                number_nx       = value;
                number_valid_nx = 1'b1;
                busy_nx         = 1'b0;
                state_nx        = IDLE;
            end else begin
                err_nx   = 1'b1;
                tens_nx  = '0;
                units_nx = '0;
                state_nx = TENS;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            number       <= '0;
            number_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            tens         <= '0;
            units        <= '0;
        end else begin
            state        <= state_nx;
            number       <= number_nx;
            number_valid <= number_valid_nx;
            err          <= err_nx;
            busy         <= busy_nx;
            tens         <= tens_nx;
            units        <= units_nx;
        end

    assign bus.number       = number;
    assign bus.number_valid = number_valid;
    assign bus.err          = err;
    assign bus.busy         = busy;
    assign bus.tens_disp    = tens;
    assign bus.units_disp   = units;
endmodule
